// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 8-digit 7-segment scan driver.
// Glyphs are active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the pins.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [3:0] SEP_CODE  = 4'hA;
  localparam seg_t       SEG_DASH  = 8'h40;
  localparam seg_t       SEG_BLANK = 8'h00;

  // Element [n] is the glyph for decimal digit n.
  localparam seg_t [9:0] DIGIT_GLYPH = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
    8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] apply_pol(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder: 0-9 digits, A dash, B-F blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  // NOTE: default assigned first so every path drives o_seg and no latch is inferred.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_nibble == SEP_CODE) begin
      o_seg = SEG_DASH;
    end else if (i_nibble <= 4'd9) begin
      o_seg = DIGIT_GLYPH[i_nibble];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver with per-frame snapshot and dead-time blanking.
// Optional leading-zero blanking of digit 7 when built with SEG7_LZB_EN defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int SLOT_HZ        = 8000,
  parameter int DEAD_CYC       = 250,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] segdata,
  output logic [7:0]  seg_com,
  output logic [7:0]  seg_out,
  output logic        frame_tick
);

  localparam int SLOT_DIV = CLK_HZ / SLOT_HZ;
  localparam int CNT_W    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
  localparam scan_state_t      RESET_ST = (DEAD_CYC == 0) ? ST_DRIVE : ST_BLANK;
  localparam bit               COM_LOW  = (COM_ACTIVE_LOW != 0);
  localparam bit               SEG_LOW  = (SEG_ACTIVE_LOW != 0);

  generate
    if (SLOT_DIV == 0 || SLOT_DIV <= DEAD_CYC) begin : g_bad_cfg
      $error("seg7_scan_driver: SLOT_DIV must be nonzero and greater than DEAD_CYC");
    end
  endgenerate

  logic [CNT_W-1:0] r_slot_cnt;
  logic [2:0]       r_digit;
  scan_state_t      r_state;
  logic [31:0]      r_snap;
  logic [7:0]       r_com;
  logic [7:0]       r_seg;
  logic             r_tick;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_digit_nxt;
  scan_state_t      w_state_nxt;
  logic             w_frame_start;
  logic [31:0]      w_frame_src;
  logic [3:0]       w_nibble;
  seg_t             w_dec;
  seg_t             w_glyph;
  logic [7:0]       w_com_nxt;
  seg_t             w_seg_nxt;

  assign w_frame_start = (r_digit == 3'd0) && (r_slot_cnt == '0);
  // Bypass the snapshot on its capture cycle so a zero dead time still shows fresh data.
  assign w_frame_src   = w_frame_start ? segdata : r_snap;
  assign w_nibble      = w_frame_src[{r_digit, 2'b00} +: 4];

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

`ifdef SEG7_LZB_EN
  assign w_glyph = ((r_digit == 3'd7) && (w_nibble == 4'h0)) ? SEG_BLANK : w_dec;
`else
  assign w_glyph = w_dec;
`endif

  always_comb begin
    w_cnt_nxt   = r_slot_cnt + 1'b1;
    w_digit_nxt = r_digit;
    w_com_nxt   = 8'h00;
    w_seg_nxt   = SEG_BLANK;
    if (r_slot_cnt == CNT_MAX) begin
      w_cnt_nxt   = '0;
      w_digit_nxt = r_digit + 3'd1;
    end
    w_state_nxt = (w_cnt_nxt < DEAD_LIM) ? ST_BLANK : ST_DRIVE;
    if (r_state == ST_DRIVE) begin
      w_com_nxt = 8'h01 << r_digit;
      w_seg_nxt = w_glyph;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt <= '0;
      r_digit    <= 3'd0;
      r_state    <= RESET_ST;
      r_snap     <= 32'h0;
      r_com      <= apply_pol(8'h00, COM_LOW);
      r_seg      <= apply_pol(SEG_BLANK, SEG_LOW);
      r_tick     <= 1'b0;
    end else begin
      r_slot_cnt <= w_cnt_nxt;
      r_digit    <= w_digit_nxt;
      r_state    <= w_state_nxt;
      if (w_frame_start) begin
        r_snap <= segdata;
      end
      r_com      <= apply_pol(w_com_nxt, COM_LOW);
      r_seg      <= apply_pol(w_seg_nxt, SEG_LOW);
      r_tick     <= w_frame_start;
    end
  end

  assign seg_com    = r_com;
  assign seg_out    = r_seg;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: SLOT_DIV=8, DEAD_CYC=2, active-low pins, 64-cycle frames.
// Expected glyphs per frame are hand-written active-low bytes, digit k at bits [8k+:8].
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] segdata;
  logic [7:0]  seg_com;
  logic [7:0]  seg_out;
  logic        frame_tick;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  com;
    logic [7:0]  seg;
    logic        tick;
    string       name;
  } exp_t;

  exp_t q[$];

`ifdef SEG7_LZB_EN
  localparam logic [7:0] Z7 = 8'hFF;
`else
  localparam logic [7:0] Z7 = 8'hC0;
`endif

  seg7_scan_driver #(
    .CLK_HZ         (16),
    .SLOT_HZ        (2),
    .DEAD_CYC       (2),
    .COM_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .segdata    (segdata),
    .seg_com    (seg_com),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation whose output cycle has been reached.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (seg_com !== e.com || seg_out !== e.seg || frame_tick !== e.tick) begin
        n_miss++;
        $display("FAIL %s: got com=%h seg=%h tick=%b, expected com=%h seg=%h tick=%b",
                 e.name, seg_com, seg_out, frame_tick, e.com, e.seg, e.tick);
      end
    end
  end

  // Expectation for the outputs that follow the next clock edge.
  task automatic step(input string name, input logic [7:0] com, input logic [7:0] seg,
                      input logic tick);
    exp_t e;
    @(posedge clk);
    #1;
    e.cyc  = cyc;
    e.com  = com;
    e.seg  = seg;
    e.tick = tick;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic run_slots(input string tag, input logic [63:0] exp_segs, input int t0,
                           input int t1);
    int         d;
    int         w;
    logic [7:0] oh;
    for (int t = t0; t < t1; t++) begin
      d  = t / 8;
      w  = t % 8;
      oh = 8'h01 << d;
      if (w < 2) step($sformatf("%s t=%0d blank", tag, t), 8'hFF, 8'hFF, (t == 0));
      else       step($sformatf("%s t=%0d dig%0d", tag, t, d), ~oh, exp_segs[8*d +: 8], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    segdata = 32'h12A34A56;
    for (int i = 0; i < 3; i++) step($sformatf("reset c%0d", i), 8'hFF, 8'hFF, 1'b0);
    reset = 1'b0;

    run_slots("mixed_f1", 64'hF9A4BFB099BF9282, 0, 64);
    run_slots("mixed_f2", 64'hF9A4BFB099BF9282, 0, 64);

    segdata = 32'h00000000;
    run_slots("tear_f1", {Z7, 56'hC0C0C0C0C0C0C0}, 0, 28);
    segdata = 32'h99999999;
    run_slots("tear_f1", {Z7, 56'hC0C0C0C0C0C0C0}, 28, 64);
    run_slots("tear_f2", 64'h9090909090909090, 0, 64);

    segdata = 32'hBCDEFA0A;
    run_slots("codes", 64'hFFFFFFFFFFBFC0BF, 0, 64);

    segdata = 32'h01A23A45;
    run_slots("lzb", {Z7, 56'hF9BFA4B0BF9992}, 0, 64);

    segdata = 32'h87654321;
    run_slots("pre_rst", 64'h80F8829299B0A4F9, 0, 44);
    reset   = 1'b1;
    segdata = 32'h76543210;
    step("midrst c0", 8'hFF, 8'hFF, 1'b0);
    step("midrst c1", 8'hFF, 8'hFF, 1'b0);
    reset = 1'b0;
    run_slots("post_rst", 64'hF8829299B0A4F9C0, 0, 64);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
